// File: rtl/day10_input_writer.sv
// Streams one day-10 machine record (light count, target, button count, button vectors)
// as W-bit AXI-stream beats; the record is captured on start and done pulses after the last beat.
module day10_input_writer #(
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_LIGHTS_W  = (MAX_NUM_LIGHTS <= 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
    parameter int AXI_DATA_WIDTH    = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      last_record,
    input  logic [MAX_NUM_LIGHTS_W-1:0]               num_lights,
    input  logic [MAX_NUM_LIGHTS-1:0]                 target_lights,
    input  logic [MAX_NUM_BUTTONS_W-1:0]              num_buttons,
    input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] buttons,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      data_out_tvalid,
    input  logic                                      data_out_tready,
    output logic [AXI_DATA_WIDTH-1:0]                 data_out_tdata,
    output logic                                      data_out_tlast
);

    localparam int W      = AXI_DATA_WIDTH;
    localparam int VMAX   = (MAX_NUM_LIGHTS + W - 1) / W;
    localparam int BEAT_W = $clog2(VMAX + 1);
    localparam int PAD_W  = VMAX * W;

    typedef enum logic [2:0] {
        IDLE,
        SEND_LIGHTS_COUNT,
        SEND_TARGET,
        SEND_BUTTON_COUNT,
        SEND_BUTTON,
        DONE
    } state_t;

    state_t                                    state;
    logic [MAX_NUM_BUTTONS_W-1:0]              buttons_cnt;
    logic [BEAT_W-1:0]                         vec_beats;
    logic [PAD_W-1:0]                          target_vec;
    logic [MAX_NUM_BUTTONS-1:0][PAD_W-1:0]     button_vecs;
    logic                                      last_flag;
    logic [BEAT_W-1:0]                         beat_cnt;
    logic [MAX_NUM_BUTTONS_W-1:0]              button_idx;

    logic [MAX_NUM_LIGHTS_W-1:0]               l_clamp;
    logic [MAX_NUM_BUTTONS_W-1:0]              b_clamp;
    logic [PAD_W-1:0]                          light_mask;
    logic [BEAT_W-1:0]                         v_in;
    logic [PAD_W-1:0]                          target_in;
    logic [MAX_NUM_BUTTONS-1:0][PAD_W-1:0]     button_in;

    state_t                                    state_n;
    logic [BEAT_W-1:0]                         beat_n;
    logic [MAX_NUM_BUTTONS_W-1:0]              idx_n;
    logic [PAD_W-1:0]                          target_shift;
    logic [PAD_W-1:0]                          button_sel;
    logic [PAD_W-1:0]                          button_shift;
    logic [W-1:0]                              next_data;
    logic                                      next_last;
    logic                                      count_is_final;
    logic                                      last_beat;
    logic                                      last_button;

    // Clamp the incoming counts and zero every vector bit at or above the light count.
    always_comb begin
        l_clamp = (num_lights > MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS))
                  ? MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS) : num_lights;
        b_clamp = (num_buttons > MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS))
                  ? MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS) : num_buttons;
        light_mask = '0;
        for (int i = 0; i < PAD_W; i++) begin
            light_mask[i] = (i < int'(l_clamp));
        end
        v_in      = BEAT_W'((int'(l_clamp) + W - 1) / W);
        target_in = PAD_W'(target_lights) & light_mask;
        for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
            button_in[b] = PAD_W'(buttons[b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS]) & light_mask;
        end
    end

    // Work out the position and contents of the beat that follows the current handshake.
    always_comb begin
        state_n        = state;
        beat_n         = beat_cnt;
        idx_n          = button_idx;
        count_is_final = (buttons_cnt == MAX_NUM_BUTTONS_W'(0)) || (vec_beats == BEAT_W'(0));
        last_beat      = (beat_cnt == vec_beats - BEAT_W'(1));
        last_button    = (button_idx == buttons_cnt - MAX_NUM_BUTTONS_W'(1));
        case (state)
            SEND_LIGHTS_COUNT: begin
                state_n = (vec_beats == BEAT_W'(0)) ? SEND_BUTTON_COUNT : SEND_TARGET;
                beat_n  = BEAT_W'(0);
            end
            SEND_TARGET: begin
                if (last_beat) begin
                    state_n = SEND_BUTTON_COUNT;
                    beat_n  = BEAT_W'(0);
                end else begin
                    beat_n  = beat_cnt + BEAT_W'(1);
                end
            end
            SEND_BUTTON_COUNT: begin
                state_n = count_is_final ? DONE : SEND_BUTTON;
                beat_n  = BEAT_W'(0);
                idx_n   = MAX_NUM_BUTTONS_W'(0);
            end
            SEND_BUTTON: begin
                if (last_beat && last_button) begin
                    state_n = DONE;
                end else if (last_beat) begin
                    beat_n  = BEAT_W'(0);
                    idx_n   = button_idx + MAX_NUM_BUTTONS_W'(1);
                end else begin
                    beat_n  = beat_cnt + BEAT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        target_shift = target_vec >> (int'(beat_n) * W);
        button_sel   = '0;
        for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
            button_sel = (idx_n == MAX_NUM_BUTTONS_W'(b)) ? button_vecs[b] : button_sel;
        end
        button_shift = button_sel >> (int'(beat_n) * W);

        case (state_n)
            SEND_TARGET:       next_data = target_shift[W-1:0];
            SEND_BUTTON_COUNT: next_data = W'(buttons_cnt);
            SEND_BUTTON:       next_data = button_shift[W-1:0];
            default:           next_data = '0;
        endcase

        // The button-count beat ends the record only when no button beats follow it.
        if (state_n == SEND_BUTTON_COUNT) begin
            next_last = last_flag && count_is_final;
        end else if (state_n == SEND_BUTTON) begin
            next_last = last_flag && (idx_n == buttons_cnt - MAX_NUM_BUTTONS_W'(1))
                        && (beat_n == vec_beats - BEAT_W'(1));
        end else begin
            next_last = 1'b0;
        end
    end

    // Record capture, beat sequencing and registered stream/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            buttons_cnt     <= '0;
            vec_beats       <= '0;
            target_vec      <= '0;
            button_vecs     <= '0;
            last_flag       <= 1'b0;
            beat_cnt        <= '0;
            button_idx      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            data_out_tvalid <= 1'b0;
            data_out_tdata  <= '0;
            data_out_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= SEND_LIGHTS_COUNT;
                        buttons_cnt     <= b_clamp;
                        vec_beats       <= v_in;
                        target_vec      <= target_in;
                        button_vecs     <= button_in;
                        last_flag       <= last_record;
                        beat_cnt        <= '0;
                        button_idx      <= '0;
                        busy            <= 1'b1;
                        data_out_tvalid <= 1'b1;
                        data_out_tdata  <= W'(l_clamp);
                        data_out_tlast  <= 1'b0;
                    end
                end
                SEND_LIGHTS_COUNT, SEND_TARGET, SEND_BUTTON_COUNT, SEND_BUTTON: begin
                    if (data_out_tvalid && data_out_tready) begin
                        state           <= state_n;
                        beat_cnt        <= beat_n;
                        button_idx      <= idx_n;
                        data_out_tdata  <= next_data;
                        data_out_tlast  <= next_last;
                        data_out_tvalid <= (state_n != DONE);
                        done            <= (state_n == DONE);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                    data_out_tvalid <= 1'b0;
                    data_out_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_day10_input_writer.sv
// Directed bench for day10_input_writer: streams hand-worked records under several
// tready patterns and compares every accepted beat against precomputed byte lists.
module tb_day10_input_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        last_record;
    logic [3:0]  num_lights;
    logic [9:0]  target_lights;
    logic [2:0]  num_buttons;
    logic [39:0] buttons;
    logic        busy;
    logic        done;
    logic        tvalid;
    logic        tready;
    logic [7:0]  tdata;
    logic        tlast;

    int checks;
    int failures;

    logic [7:0] got_d[$];
    logic       got_l[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];

    day10_input_writer #(
        .MAX_NUM_LIGHTS (10),
        .MAX_NUM_BUTTONS(4),
        .AXI_DATA_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .last_record    (last_record),
        .num_lights     (num_lights),
        .target_lights  (target_lights),
        .num_buttons    (num_buttons),
        .buttons        (buttons),
        .busy           (busy),
        .done           (done),
        .data_out_tvalid(tvalid),
        .data_out_tready(tready),
        .data_out_tdata (tdata),
        .data_out_tlast (tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_record(input logic [3:0] l, input logic [9:0] t, input logic [2:0] b,
                              input logic [9:0] b0, input logic [9:0] b1,
                              input logic [9:0] b2, input logic [9:0] b3, input logic lr);
        num_lights    = l;
        target_lights = t;
        num_buttons   = b;
        buttons       = {b3, b2, b1, b0};
        last_record   = lr;
    endtask

    // mode 0: tready high; 1: toggling; 2: toggling with 5 low cycles before beat 4;
    // 3: tready high, inputs scrambled and start re-pulsed while busy
    task automatic collect(input int mode, output int ncyc);
        logic       held_v;
        logic [7:0] held_d;
        logic       held_l;
        int         hold_cnt;
        got_d.delete();
        got_l.delete();
        held_v   = 1'b0;
        held_d   = '0;
        held_l   = 1'b0;
        hold_cnt = 0;
        ncyc     = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (mode == 1) begin
                tready = (cyc % 2 == 0);
            end else if (mode == 2) begin
                if (got_d.size() == 4 && hold_cnt < 5) begin
                    tready = 1'b0;
                    hold_cnt++;
                end else begin
                    tready = (cyc % 2 == 0);
                end
            end else begin
                tready = 1'b1;
            end
            if (mode == 3 && cyc == 0) begin
                set_record(4'd7, 10'h3FF, 3'd3, 10'h111, 10'h222, 10'h333, 10'h044, 1'b0);
            end
            start = (mode == 3 && cyc == 1);
            if (held_v) begin
                check("stall_tvalid", {31'd0, tvalid}, 32'd1);
                check("stall_tdata", {24'd0, tdata}, {24'd0, held_d});
                check("stall_tlast", {31'd0, tlast}, {31'd0, held_l});
                held_v = 1'b0;
            end
            if (done) begin
                ncyc = cyc;
                break;
            end
            if (tvalid && tready) begin
                got_d.push_back(tdata);
                got_l.push_back(tlast);
            end else if (tvalid) begin
                held_v = 1'b1;
                held_d = tdata;
                held_l = tlast;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (ncyc < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic run(input string tag, input int mode);
        int ncyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_latency_tvalid"}, {31'd0, tvalid}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        collect(mode, ncyc);
        check({tag, "_beat_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), {24'd0, got_d[i]}, {24'd0, exp_d[i]});
            check($sformatf("%s_last%0d", tag, i), {31'd0, got_l[i]}, {31'd0, exp_l[i]});
        end
        if (mode == 0 || mode == 3) begin
            check({tag, "_done_cycle"}, ncyc, exp_d.size());
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        tready   = 1'b1;
        set_record(4'd0, 10'h0, 3'd0, 10'h0, 10'h0, 10'h0, 10'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tlast", {31'd0, tlast}, 32'd0);
        check("rst_tdata", {24'd0, tdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_record(4'd4, 10'b0110, 3'd2, 10'b1000, 10'b1010, 10'h0, 10'h0, 1'b1);
        exp_d = '{8'h04, 8'h06, 8'h02, 8'h08, 8'h0A};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run("basic", 0);

        set_record(4'd10, 10'h2A5, 3'd1, 10'h3FF, 10'h0, 10'h0, 10'h0, 1'b1);
        exp_d = '{8'h0A, 8'hA5, 8'h02, 8'h01, 8'hFF, 8'h03};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run("wide", 0);

        set_record(4'd10, 10'h2A5, 3'd1, 10'h3FF, 10'h0, 10'h0, 10'h0, 1'b1);
        run("backpressure", 2);
        run("toggle", 1);

        set_record(4'd3, 10'h3FD, 3'd0, 10'h3FF, 10'h0, 10'h0, 10'h0, 1'b1);
        exp_d = '{8'h03, 8'h05, 8'h00};
        exp_l = '{1'b0, 1'b0, 1'b1};
        run("nobuttons_last", 0);

        set_record(4'd3, 10'h3FD, 3'd0, 10'h3FF, 10'h0, 10'h0, 10'h0, 1'b0);
        exp_l = '{1'b0, 1'b0, 1'b0};
        run("nobuttons_nolast", 0);

        set_record(4'd4, 10'b0110, 3'd2, 10'b1000, 10'b1010, 10'h0, 10'h0, 1'b1);
        exp_d = '{8'h04, 8'h06, 8'h02, 8'h08, 8'h0A};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run("ignore_restart", 3);

        set_record(4'd12, 10'h3FF, 3'd1, 10'h155, 10'h0, 10'h0, 10'h0, 1'b1);
        exp_d = '{8'h0A, 8'hFF, 8'h03, 8'h01, 8'h55, 8'h01};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run("clamp_lights", 0);

        set_record(4'd2, 10'h3FF, 3'd6, 10'h3FF, 10'h001, 10'h002, 10'h3FC, 1'b0);
        exp_d = '{8'h02, 8'h03, 8'h04, 8'h03, 8'h01, 8'h02, 8'h00};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run("clamp_buttons", 0);

        // Abort a record with an asynchronous reset while the target beat is stalled.
        set_record(4'd10, 10'h2A5, 3'd1, 10'h3FF, 10'h0, 10'h0, 10'h0, 1'b1);
        tready = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tready = 1'b0;
        check("abort_pre_tdata", {24'd0, tdata}, 32'h000000A5);
        #2 rst = 1'b1;
        #1;
        check("abort_tvalid", {31'd0, tvalid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_tlast", {31'd0, tlast}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        tready = 1'b1;
        @(negedge clk);

        set_record(4'd4, 10'b0110, 3'd2, 10'b1000, 10'b1010, 10'h0, 10'h0, 1'b1);
        exp_d = '{8'h04, 8'h06, 8'h02, 8'h08, 8'h0A};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run("after_abort", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
